// File: rtl/mem_responder.sv
// Pipelined word-addressed main-memory model answering cache refill reads and
// write-through writes; read data returns a fixed LATENCY cycles after issue.
module mem_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned WORDS_LOG2 = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] rd_addr,
    output logic [3:0]  pending,
    output logic        idle
);

    localparam int unsigned DEPTH = 1 << WORDS_LOG2;

    logic [15:0]           mem [DEPTH];
    logic [WORDS_LOG2-1:0] index;
    logic                  issue;
    logic                  retire;
    logic                  unused_byte_bit;

    logic [15:0] pipe_addr  [LATENCY];
    logic [15:0] pipe_data  [LATENCY];
    logic        pipe_valid [LATENCY];

    assign index           = addr[WORDS_LOG2:1];
    assign issue           = enable & ~wr;
    assign retire          = pipe_valid[LATENCY-1];
    assign unused_byte_bit = addr[0];

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (enable && wr) begin
            mem[index] <= data_in;
        end
    end

    // Stage 0 snapshots the word as it stood before this edge's write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid[0] <= 1'b0;
            pipe_addr[0]  <= '0;
            pipe_data[0]  <= '0;
        end else begin
            pipe_valid[0] <= issue;
            pipe_addr[0]  <= issue ? {addr[15:1], 1'b0} : '0;
            pipe_data[0]  <= issue ? mem[index] : '0;
        end
    end

    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_valid[g] <= 1'b0;
                pipe_addr[g]  <= '0;
                pipe_data[g]  <= '0;
            end else begin
                pipe_valid[g] <= pipe_valid[g-1];
                pipe_addr[g]  <= pipe_addr[g-1];
                pipe_data[g]  <= pipe_data[g-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (issue && !retire) begin
            pending <= pending + 4'd1;
        end else if (!issue && retire) begin
            pending <= pending - 4'd1;
        end
    end

    // Empty stages carry zeros, so the last stage already reads 0 when not valid.
    assign data_valid = pipe_valid[LATENCY-1];
    assign data_out   = pipe_data[LATENCY-1];
    assign rd_addr    = pipe_addr[LATENCY-1];
    assign idle       = (pending == 4'd0) && !enable;

endmodule
